// File: rtl/fifo_sync_flags.sv
// ---------------------------------------------------------------------------
// fifo_sync_flags
//
// Single-clock elastic FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds and sticky overflow / underflow error flags.
// Read data is registered (one cycle latency) and qualified by valid_out.
//
// Parameters
//   DATA_W     data word width (>= 1)
//   DEPTH      number of entries (>= 2, need not be a power of two)
//   AFULL_TH   almost_full  when count >= AFULL_TH  (1..DEPTH)
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH (0..DEPTH-1)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset, overrides everything
//   en           global enable; 0 freezes all state and ignores requests
//   we / data_in write request and write data
//   re           read request
//   data_out     registered read data (holds when no read is accepted)
//   valid_out    1-cycle strobe: data_out was updated by the last edge
//   count        occupancy 0..DEPTH
//   Empty, Full, almost_empty, almost_full  decodes of registered count
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
//   clr_err      clears overflow/underflow (a new error in the same cycle wins)
// ---------------------------------------------------------------------------
module fifo_sync_flags #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CW-1:0]     count,
  output logic              Empty,
  output logic              Full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  // Storage: no reset so it maps onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [DATA_W-1:0] data_out_reg;
  logic              valid_out_reg;
  logic              overflow_reg, overflow_next;
  logic              underflow_reg, underflow_next;
  logic              rd_ok, wr_ok;

  always_comb begin
    // Acceptance uses the pre-edge count. A write into a full FIFO is
    // accepted only when a read frees a slot in the same cycle.
    rd_ok = en && re && (count_reg != '0);
    wr_ok = en && we && ((count_reg != DEPTH_C) || rd_ok);

    // Explicit wrap compare keeps non-power-of-two depths correct.
    rd_ptr_next = rd_ptr_reg;
    if (rd_ok) begin
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + AW'(1);
    end

    wr_ptr_next = wr_ptr_reg;
    if (wr_ok) begin
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + AW'(1);
    end

    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // Clear first, then set, so a fresh error in the clearing cycle survives.
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (en && clr_err) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (en && we && !wr_ok) begin
      overflow_next = 1'b1;
    end
    if (en && re && !rd_ok) begin
      underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      valid_out_reg <= rd_ok;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      // When full with a simultaneous read/write, rd_ptr == wr_ptr; the
      // registered read sees the old word, so the oldest entry is returned.
      if (rd_ok) begin
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  assign data_out     = data_out_reg;
  assign valid_out    = valid_out_reg;
  assign count        = count_reg;
  assign Empty        = (count_reg == '0);
  assign Full         = (count_reg == DEPTH_C);
  assign almost_empty = (count_reg <= AEMPTY_C);
  assign almost_full  = (count_reg >= AFULL_C);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: doc/fifo_sync_flags.md
# fifo_sync_flags

Parametrised single-clock FIFO; next generation of the team's 32×8 buffer. Generalised data width and depth, simultaneous read/write in one cycle, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between a producer and a consumer in the same clock domain as an elastic buffer. Registered read data carries a valid strobe.

## Interface
- DATA_W, 32, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer, power of two not required)
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)
- CW (local), $clog2(DEPTH+1), count width
- AW (local), max(1,$clog2(DEPTH)), pointer width

Ports (name, direction, width, meaning):
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; 0 freezes all state, inputs ignored
- we  in  1  write request
- data_in  in  DATA_W  write data, sampled when write accepted
- re  in  1  read request
- data_out  out  DATA_W  registered read data
- valid_out  out  1  one-cycle strobe: data_out updated this cycle
- count  out  CW  current occupancy, 0..DEPTH
- Empty  out  1  count == 0
- Full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AEMPTY_TH
- almost_full  out  1  count ≥ AFULL_TH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected
- clr_err  in  1  clears overflow/underflow (synchronous, 1 cycle)

## Operation
- State: storage array DEPTH×DATA_W, rd_ptr and wr_ptr (AW bits), count (CW bits), data_out, valid_out, overflow, underflow.
- Acceptance, evaluated on pre-edge count, only when en=1:
  - rd_ok = re && count != 0
  - wr_ok = we && (count != DEPTH || rd_ok)
- Full with re=we=1: both accepted, count stays DEPTH; the read returns the oldest word, not the one being written.
- Empty with re=we=1: write accepted, read rejected, underflow set, count → 1.
- rd_ok: data_out ← mem[rd_ptr]; rd_ptr advances; valid_out=1 next cycle. Otherwise valid_out=0 and data_out holds.
- wr_ok: mem[wr_ptr] ← data_in; wr_ptr advances.
- Pointer wrap: ptr == DEPTH-1 advances to 0 (explicit compare, correct for non-power-of-two DEPTH).
- count next = count + wr_ok − rd_ok; never exceeds DEPTH, never below 0.
- Flags Empty/Full/almost_* are combinational decodes of registered count only; no other inputs.
- overflow set on we && !wr_ok; underflow set on re && !rd_ok; both gated by en.
- clr_err clears the flags. Set beats clear when both occur in the same cycle.
- en=0: pointers, count, memory, data_out, error flags hold; valid_out=0.
- rst has priority over en and all requests.

## Timing
- Reset values: data_out=0, valid_out=0, count=0, Empty=1, Full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Pointers = 0. Memory not cleared.
- Reset mid-operation discards all contents in that cycle. Requests during rst are ignored and do not set error flags.
- Read latency: 1 cycle. re accepted at edge N gives data_out/valid_out at N+1.
- Write-to-read: word written at edge N is readable by a re at edge N+1. Empty deasserts after edge N.
- Flags and count reflect post-edge state in the same cycle as the edge (no extra latency).
- Throughput: one read and one write per cycle sustained.

## Test plan
- Reset with DEPTH=16: assert rst 2 cycles mid-traffic -> count=0, Empty=1, almost_empty=1, data_out=0, valid_out=0, error flags 0.
- Fill/drain: write 0x0..0xF on 16 cycles, then 17th write -> Full=1 after 16th, overflow=1. Then read 16 -> data 0x0..0xF in order, valid_out each cycle. 17th read -> underflow=1, Empty=1.
- Simultaneous at boundaries: at count=16 drive re=we=1 with data_in=0xAA -> count stays 16, no overflow, data_out = oldest word. At count=0 drive re=we=1 -> count=1, underflow=1, valid_out=0.
- Wrap with non-power-of-two: DEPTH=5, stream 12 words with re/we overlapped -> output sequence matches input, pointers wrap 4→0, count never >5.
- Thresholds/en: AFULL_TH=14, AEMPTY_TH=2 -> almost_full rises on 14th write and almost_empty falls on 3rd. Holding en=0 with re=we=1 for 3 cycles -> no change to count or flags.
- Error clear: set overflow, then assert clr_err with no rejected write -> 0 next cycle. Assert clr_err in the same cycle as a rejected read -> underflow stays 1.
